alu_muldiv: RTL
===============

# alu_muldiv

Parametrised, handshaked successor to the datapath ALU. It executes single-cycle integer operations with a registered result and adds iterative unsigned multiply and divide, with HI/LO-style results, for the MIPS execute stage. Operand width is a parameter, and all results leave through one registered output port marked by a valid pulse. The issue stage drives it through a valid/ready handshake, and the register-write stage consumes the result.

## Interface
- WIDTH, 32, operand and result width in bits, ≥ 4, power of two
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and opcode presented
- in_ready  out  1  block can accept this cycle
- aluop  in  4  operation select
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- out  out  WIDTH  result, or LO/quotient
- hi  out  WIDTH  HI/remainder (mult/div), else 0
- zeroflag  out  1  in1 == in2 for the accepted operation
- divzero  out  1  div issued with in2 == 0
- out_valid  out  1  one-cycle pulse: out/hi/zeroflag/divzero are new

## Operation
- Accept occurs when in_valid && in_ready at a rising edge; aluop/in1/in2 are captured, and later input changes have no effect.
- aluop encoding:
  - 0 add, wrap modulo 2^WIDTH
  - 1 sub, wrap
  - 2 and
  - 3 or
  - 4 xor
  - 5 nor
  - 6 sll by in2[SHW-1:0]
  - 7 srl by in2[SHW-1:0]
  - 8 sra by in2[SHW-1:0]
  - 9 slt, signed, result 0/1
  - 10 sltu, unsigned
  - 11 mult, unsigned
  - 12 div, unsigned
  - 13–15 reserved: out = 0, hi = 0, single-cycle
- Upper shift-amount bits are ignored.
- mult: {hi,out} = full 2·WIDTH-bit product. Shift-add, one bit per cycle.
- div: out = quotient, hi = remainder. Restoring division, one bit per cycle.
- div by zero: out = all ones, hi = in1, divzero = 1, no iteration (single-cycle latency).
- Non-mult/div ops: hi = 0, divzero = 0.
- zeroflag is computed from the captured operands for every op and updated with the result.
- FSM:
  - IDLE: in_ready = 1. Accept of mult/div (nonzero divisor) loads the iteration counter with WIDTH and goes to RUN. Any other accept writes the result directly and stays in IDLE.
  - RUN: in_ready = 0. One iteration per edge; the counter decrements. On the edge where the counter reaches 0, the result is written, out_valid is set and the FSM returns to IDLE.
- Outputs hold their last value until the next result write.
- Reset values: out = 0, hi = 0, zeroflag = 0, divzero = 0, out_valid = 0, FSM = IDLE, counter = 0.
- in_ready = 0 while rst is high.
- Reset mid-RUN aborts the operation: no out_valid, partial result discarded, in_ready = 1 on the first cycle after rst deasserts.

## Timing
- Single-cycle ops (including reserved opcodes and div-by-zero):
  - Accepted at edge N; results updated at edge N; out_valid high for the cycle after N.
  - Throughput 1 per cycle; in_ready stays 1.
- mult/div:
  - Accepted at edge N; iterations at edges N+1 … N+WIDTH; result and out_valid set at edge N+WIDTH.
  - in_ready low from after edge N until edge N+WIDTH; high again in the out_valid cycle, so back-to-back issue is allowed.
- out_valid is never high for two consecutive cycles from the same operation.
- There is no output backpressure; the consumer must take the result in the out_valid cycle.
- Simultaneous rst and in_valid: reset wins, nothing is accepted.

## Test plan
- WIDTH = 32. Add 10 + 5 at edge N → out = 15, zeroflag = 0, out_valid high only in cycle N+1. Sub 10 − 5 next cycle → out = 5. Back-to-back, in_ready constantly 1.
- Sub 5 − 5 → out = 0, zeroflag = 1. sll 1 by in2 = 33 → out = 2 (mask). sra 0x80000000 by 4 → 0xF8000000. srl 0x80000000 by 4 → 0x08000000.
- slt in1 = 0xFFFFFFFF, in2 = 1 → 1. sltu with the same operands → 0. Reserved opcode 14 → out = 0, hi = 0, out_valid after 1 edge.
- mult 0xFFFFFFFF × 2 → hi = 1, out = 0xFFFFFFFE exactly 32 edges after accept. in_ready low for cycles N+1 … N+32, high in the out_valid cycle. in_valid asserted with changing operands during RUN is ignored.
- div 100 / 7 → out = 14, hi = 2, divzero = 0 after 32 edges. div 9 / 0 → out = 0xFFFFFFFF, hi = 9, divzero = 1, one-cycle latency.
- Start mult, assert rst for 1 cycle at accept + 10 → no out_valid; out = 0, hi = 0 after reset; next add is accepted on the first post-reset cycle. Repeat with WIDTH = 8: mult 0xFF × 0xFF → hi = 0xFE, out = 0x01 after 8 edges.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS execute-stage ALU with iterative unsigned multiply/divide.
//   Single-cycle ops write a registered result in the accept cycle. mult and
//   div (nonzero divisor) iterate one bit per clock for WIDTH clocks.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   issue handshake; accept = in_valid && in_ready
//   aluop, in1, in2     opcode and operands, captured on accept
//   out, hi             result / LO-quotient, HI-remainder
//   zeroflag            in1 == in2 for the operation producing the result
//   divzero             div issued with in2 == 0
//   out_valid           one-cycle pulse marking a new result
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zeroflag,
    output logic             divzero,
    output logic             out_valid
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend->quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor
    logic             is_div_q, is_div_d;
    logic             eq_q, eq_d;           // zeroflag held until result write
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zf_q, zf_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic             accept;
    logic             slow_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_lo, alu_hi;
    logic             alu_dz;
    logic [WIDTH:0]   mul_sum, div_rs, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign slow_op   = (aluop == 4'd11) || (aluop == 4'd12 && in2 != '0);
    assign shamt     = in2[SHW-1:0];

    assign out       = out_q;
    assign hi        = hi_q;
    assign zeroflag  = zf_q;
    assign divzero   = dz_q;
    assign out_valid = ov_q;

    // Single-cycle datapath; mult/div entries are unused (handled iteratively)
    // except the divide-by-zero shortcut.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        alu_dz = 1'b0;
        case (aluop)
            4'd0:  alu_lo = in1 + in2;
            4'd1:  alu_lo = in1 - in2;
            4'd2:  alu_lo = in1 & in2;
            4'd3:  alu_lo = in1 | in2;
            4'd4:  alu_lo = in1 ^ in2;
            4'd5:  alu_lo = ~(in1 | in2);
            4'd6:  alu_lo = in1 << shamt;
            4'd7:  alu_lo = in1 >> shamt;
            4'd8:  alu_lo = WIDTH'($signed(in1) >>> shamt);
            4'd9:  alu_lo = WIDTH'($signed(in1) < $signed(in2));
            4'd10: alu_lo = WIDTH'(in1 < in2);
            4'd12: begin
                alu_lo = '1;
                alu_hi = in1;
                alu_dz = 1'b1;
            end
            default: alu_lo = '0;
        endcase
    end

    // One iteration. mult: shift-add on {acc_hi, acc_lo}, product shifts in
    // from the top while the multiplier drains from the bottom. div: restoring,
    // remainder in acc_hi, quotient bits shift into acc_lo as dividend leaves.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rs   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_rs - {1'b0, opnd_q};
        if (is_div_q) begin
            // A borrow out of the top bit means the trial subtract failed.
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_rs[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        eq_d     = eq_q;
        out_d    = out_q;
        hi_d     = hi_q;
        zf_d     = zf_q;
        dz_d     = dz_q;
        ov_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (slow_op) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (aluop == 4'd12);
                        eq_d     = (in1 == in2);
                        acc_hi_d = '0;
                        acc_lo_d = (aluop == 4'd12) ? in1 : in2;
                        opnd_d   = (aluop == 4'd12) ? in2 : in1;
                    end else begin
                        out_d = alu_lo;
                        hi_d  = alu_hi;
                        zf_d  = (in1 == in2);
                        dz_d  = alu_dz;
                        ov_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d    = cnt_q - CW'(1);
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    out_d   = step_lo;
                    hi_d    = step_hi;
                    zf_d    = eq_q;
                    dz_d    = 1'b0;
                    ov_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            eq_q     <= 1'b0;
            out_q    <= '0;
            hi_q     <= '0;
            zf_q     <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            eq_q     <= eq_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            zf_q     <= zf_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
        end
    end

endmodule
